// File: rtl/cnn_pkg.sv
// Shared widths and FSM encoding for the partial-sum accumulate / ReLU path.
package cnn_pkg;

    localparam int PSUM_W_DEF = 20;
    localparam int ACC_W_DEF  = 24;
    localparam int OUT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantiser: ReLU, round-half-up, right shift, unsigned saturate.
module psum_requant #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] sum_i,
    input  logic [4:0]       shift_i,
    output logic [OUT_W-1:0] result_o
);

    // One extra bit so the rounding addend cannot overflow a maximal positive sum.
    localparam int W = ACC_W + 1;

    logic [W-1:0] pos;
    logic [W-1:0] rnd;
    logic [W-1:0] rounded;
    logic [W-1:0] shifted;

    // Negative sums clamp to zero; positive sums are rounded, shifted and clipped.
    always_comb begin
        pos      = {1'b0, sum_i};
        rnd      = (shift_i == 5'd0) ? '0 : (W'(1) << (shift_i - 5'd1));
        rounded  = pos + rnd;
        shifted  = rounded >> shift_i;
        result_o = '0;
        if (sum_i[ACC_W-1]) begin
            result_o = '0;
        end else if (shifted[W-1:OUT_W] != '0) begin
            result_o = '1;
        end else begin
            result_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/psum_acc_relu.sv
// Column partial-sum accumulator with saturating add, requantised ofmap output
// held until the consumer accepts it, delivered-result counter and sticky error.
module psum_acc_relu
    import cnn_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              gclk,
    input  logic              rst,
    input  logic [PSUM_W-1:0] psum_in,
    input  logic              psum_valid,
    input  logic              psum_first,
    input  logic              psum_last,
    output logic              psum_ready,
    input  logic [4:0]        shift,
    output logic [OUT_W-1:0]  ofmap,
    output logic              ofmap_valid,
    input  logic              ofmap_ready,
    output logic [15:0]       out_cnt,
    output logic              err
);

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [OUT_W-1:0]   ofmap_q;
    logic               ofmap_valid_q;
    logic [15:0]        out_cnt_q;
    logic               err_q;

    logic [ACC_W-1:0]   psum_ext;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sat_sum;
    logic [OUT_W-1:0]   req_res;
    logic               beat_ok;

    assign psum_ready  = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign beat_ok     = psum_valid && psum_ready;
    assign ofmap       = ofmap_q;
    assign ofmap_valid = ofmap_valid_q;
    assign out_cnt     = out_cnt_q;
    assign err         = err_q;

    // Post-update sum: a first beat restarts, otherwise add with signed saturation.
    always_comb begin
        psum_ext = ACC_W'($signed(psum_in));
        sum_wide = {acc_q[ACC_W-1], acc_q} + {psum_ext[ACC_W-1], psum_ext};
        sat_sum  = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sat_sum = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
        acc_d = psum_first ? psum_ext : sat_sum;
    end

    // The requantiser sees the post-update sum so the last beat's result is
    // captured on the same edge that accepts it.
    psum_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .sum_i    (acc_d),
        .shift_i  (shift),
        .result_o (req_res)
    );

    // Accumulate / output FSM with registered ofmap, counter and error flag.
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            ofmap_q       <= '0;
            ofmap_valid_q <= 1'b0;
            out_cnt_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_ok) begin
                        if (psum_first) begin
                            acc_q <= acc_d;
                            if (psum_last) begin
                                ofmap_q       <= req_res;
                                ofmap_valid_q <= 1'b1;
                                state_q       <= ST_OUT;
                            end else begin
                                state_q <= ST_ACC;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (beat_ok) begin
                        acc_q <= acc_d;
                        if (psum_last) begin
                            ofmap_q       <= req_res;
                            ofmap_valid_q <= 1'b1;
                            state_q       <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (ofmap_ready) begin
                        ofmap_valid_q <= 1'b0;
                        out_cnt_q     <= out_cnt_q + 16'd1;
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/psum_acc_relu.md
PSUM_ACC_RELU -- requirements
Module: psum_acc_relu

Interface
REQ-001 Parameter PSUM_W, default 20, width of the signed partial sum from the bottom PE of a column.
REQ-002 Parameter ACC_W, default 24, width of the signed accumulator.
REQ-003 Parameter OUT_W, default 8, width of the unsigned ofmap output.
REQ-004 gclk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 psum_in  input  PSUM_W  signed partial sum from the PE column.
REQ-007 psum_valid  input  1  psum_in carries a beat.
REQ-008 psum_first  input  1  beat opens a new accumulation.
REQ-009 psum_last  input  1  beat closes the current accumulation.
REQ-010 psum_ready  output  1  block accepts a beat this cycle.
REQ-011 shift  input  5  requantisation right-shift amount (0..23).
REQ-012 ofmap  output  OUT_W  unsigned requantised result.
REQ-013 ofmap_valid  output  1  ofmap holds a result.
REQ-014 ofmap_ready  input  1  consumer takes ofmap this cycle.
REQ-015 out_cnt  output  16  count of results delivered, wraps at 65535->0.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Beat accepted iff psum_valid && psum_ready at a rising gclk edge; psum_ready = 1 in IDLE and ACC, 0 in OUT.
REQ-018 FSM states IDLE, ACC, OUT; IDLE is the reset state.
REQ-019 Accepted beat with psum_first, in IDLE or ACC: acc <= sign-extended psum_in (any open accumulation discarded).
REQ-020 Accepted beat without psum_first in ACC: acc <= acc + sign-extended psum_in, saturating to ACC_W signed limits (+8388607 / -8388608 at default).
REQ-021 Accepted beat without psum_first in IDLE: ignored, acc unchanged, err <= 1.
REQ-022 Transitions: IDLE->ACC on accepted first without last; any accepted beat with last (in IDLE only together with first) -> OUT; OUT->IDLE on ofmap_ready; all others hold.
REQ-023 first and last on the same beat: single-beat result from psum_in alone.
REQ-024 Result on last beat, computed from the post-update sum S: S<0 -> 0 (ReLU); else R = (S + (shift>0 ? 2^(shift-1) : 0)) >> shift; R > 2^OUT_W-1 -> 2^OUT_W-1.
REQ-025 Result registered into ofmap on the same edge that accepts the last beat; ofmap_valid = 1 in the following cycle (latency 1).
REQ-026 In OUT, ofmap and ofmap_valid held stable until ofmap_ready; ofmap_valid = 0 in the cycle after the handshake.
REQ-027 out_cnt increments by 1 on each ofmap_valid && ofmap_ready.
REQ-028 shift sampled only on the last-beat edge; changes at other times have no effect.
REQ-029 err clears only on reset.

Reset
REQ-030 rst asserted, at any time including mid-accumulation or while in OUT: state IDLE, acc 0, ofmap 0, ofmap_valid 0, out_cnt 0, err 0, psum_ready 1 after release.
REQ-031 No beat accepted while rst is high.

Structure
REQ-032 Shared package cnn_pkg holds PSUM_W, ACC_W, OUT_W defaults and the FSM state encoding.
REQ-033 ReLU/round/shift/saturate is a combinational sub-module psum_requant; accumulator, FSM and counters sit in psum_acc_relu.

Verification
REQ-034 psum 300 with first+last, shift 0 -> ofmap 255, ofmap_valid high one cycle after acceptance.
REQ-035 beats 100(first), 50, -30(last), shift 2 -> S=120, ofmap 30.
REQ-036 beat -500 with first+last -> ofmap 0; out_cnt increments on the handshake.
REQ-037 Result pending, ofmap_ready low for 3 cycles -> psum_ready 0 and ofmap stable; ofmap_ready high -> IDLE, psum_ready 1 on the next cycle.
REQ-038 Beat without first in IDLE -> acc unchanged, no output, err 1 until rst.
REQ-039 rst pulse after 2 of 4 beats -> all outputs 0; a new first..last sequence then gives the correct result.
